// File: rtl/conv_out_framer.sv
// conv_out_framer: pairs each upstream pixel slot with the convolution core
// result that follows it one cycle later. Each pairing becomes one framed
// output pixel with raster coordinates, frame/row markers and a frame-done
// pulse.
//
// Stream semantics: all interfaces here are valid-only (no ready). A slot
// exists in cycle t when in_valid=1. conv_valid/conv_pix in cycle t+1 belong
// to that slot. Its framed pixel appears with out_valid=1 in cycle t+2, and
// every output field is meaningful only while out_valid=1.
module conv_out_framer #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256,
   parameter int BITW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   input  logic            conv_valid,
   input  logic [BITW-1:0] conv_pix,
   output logic            out_valid,
   output logic [BITW-1:0] out_pix,
   output logic [15:0]     out_col,
   output logic [15:0]     out_row,
   output logic            out_sof,
   output logic            out_eol,
   output logic            out_eof,
   output logic            busy,
   output logic            done,
   output logic [31:0]     valid_cnt,
   output logic            err,
   output logic [1:0]      fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0] NPIX     = 32'(WIDTH * HEIGHT);
   localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);

   state_t      state, state_nxt;
   logic        arm;        // IDLE->RUN transition happens at this edge
   logic        slot_ok;    // current in_valid becomes a frame slot
   logic        bad_in;     // in_valid outside a slot window
   logic        bad_conv;   // conv_valid with no slot one cycle earlier
   logic        slot_q;     // a slot was issued last cycle; its result is on conv_*
   logic [31:0] issued;     // slots issued in the current frame
   logic [15:0] col_cnt;    // coordinates of the next pixel to emit
   logic [15:0] row_cnt;

   // Next-state logic; leaving RUN keys off the registered last-pixel emission
   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               arm       = 1'b1;
            end
         end
         S_RUN: begin
            if (out_valid && out_eof) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Slot acceptance and protocol-error detection
   always_comb begin
      slot_ok  = in_valid && (state == S_RUN) && (issued < NPIX);
      bad_in   = in_valid && !slot_ok;
      bad_conv = conv_valid && !slot_q;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Slot pipeline and registered framed output
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q    <= 1'b0;
         out_valid <= 1'b0;
         out_pix   <= '0;
         out_col   <= '0;
         out_row   <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         slot_q    <= slot_ok;
         out_valid <= slot_q;
         out_pix   <= (slot_q && conv_valid) ? conv_pix : '0;
         out_sof   <= slot_q && (col_cnt == 16'd0) && (row_cnt == 16'd0);
         out_eol   <= slot_q && (col_cnt == LAST_COL);
         out_eof   <= slot_q && (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);
         if (slot_q) begin
            out_col <= col_cnt;
            out_row <= row_cnt;
         end
      end
   end

   // Frame counters: raster position, issued slots, valid count, sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         issued    <= '0;
         col_cnt   <= '0;
         row_cnt   <= '0;
         valid_cnt <= '0;
         err       <= 1'b0;
      end else if (arm) begin
         issued    <= '0;
         col_cnt   <= '0;
         row_cnt   <= '0;
         valid_cnt <= '0;
         err       <= 1'b0;
      end else begin
         if (slot_ok) issued <= issued + 32'd1;
         if (slot_q) begin
            if (col_cnt == LAST_COL) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + 16'd1;
            end else begin
               col_cnt <= col_cnt + 16'd1;
            end
         end
         if (slot_q && conv_valid && (valid_cnt != 32'hFFFF_FFFF))
            valid_cnt <= valid_cnt + 32'd1;
         if (bad_in || bad_conv) err <= 1'b1;
      end
   end

   // Status outputs decoded from the state register
   always_comb begin
      busy      = (state == S_RUN);
      done      = (state == S_DONE);
      fsm_state = state;
   end

endmodule

// File: tb/tb_conv_out_framer.sv
// Bench for conv_out_framer: a 4x3 instance for directed/random framing
// scenarios and a default 256x256 instance fed with a Sobel-X style result
// stream. Expected pixels come from a slot-index model and an exact-cycle
// scoreboard.
module tb_conv_out_framer;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  pix;
      logic [15:0] col;
      logic [15:0] row;
      logic        sof;
      logic        eol;
      logic        eof;
   } exp_t;

   localparam int SW = 4;
   localparam int SH = 3;
   localparam int SN = SW * SH;
   localparam int LN = 256 * 256;

   logic clk;
   logic rst;
   int   cyc = 0;

   // small instance signals
   logic        s_start, s_in_valid, s_conv_valid;
   logic [7:0]  s_conv_pix, s_out_pix;
   logic        s_out_valid, s_out_sof, s_out_eol, s_out_eof, s_busy, s_done, s_err;
   logic [15:0] s_out_col, s_out_row;
   logic [31:0] s_valid_cnt;
   logic [1:0]  s_fsm_state;

   // large instance signals
   logic        l_start, l_in_valid, l_conv_valid;
   logic [7:0]  l_conv_pix, l_out_pix;
   logic        l_out_valid, l_out_sof, l_out_eol, l_out_eof, l_busy, l_done, l_err;
   logic [15:0] l_out_col, l_out_row;
   logic [31:0] l_valid_cnt;
   logic [1:0]  l_fsm_state;

   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 0;
   exp_t exp_q[$];
   exp_t expl_q[$];
   int   exp_done_cyc = -1;
   int   exp_vcnt = 0;
   bit   exp_err = 0;
   int   l_emit_cnt = 0;
   logic [7:0] img [LN];

   conv_out_framer #(.WIDTH(SW), .HEIGHT(SH), .BITW(8)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid),
      .conv_valid(s_conv_valid), .conv_pix(s_conv_pix),
      .out_valid(s_out_valid), .out_pix(s_out_pix), .out_col(s_out_col),
      .out_row(s_out_row), .out_sof(s_out_sof), .out_eol(s_out_eol),
      .out_eof(s_out_eof), .busy(s_busy), .done(s_done),
      .valid_cnt(s_valid_cnt), .err(s_err), .fsm_state(s_fsm_state)
   );

   conv_out_framer dut_l (
      .clk(clk), .rst(rst), .start(l_start), .in_valid(l_in_valid),
      .conv_valid(l_conv_valid), .conv_pix(l_conv_pix),
      .out_valid(l_out_valid), .out_pix(l_out_pix), .out_col(l_out_col),
      .out_row(l_out_row), .out_sof(l_out_sof), .out_eol(l_out_eol),
      .out_eof(l_out_eof), .busy(l_busy), .done(l_done),
      .valid_cnt(l_valid_cnt), .err(l_err), .fsm_state(l_fsm_state)
   );

   // clock and cycle index
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   // expected framed pixel for slot k of the 4x3 frame, issued this cycle
   task automatic push_s(input int k, input bit cv, input logic [7:0] pix);
      exp_t e;
      e.cyc = 32'(cyc + 2);
      e.pix = cv ? pix : 8'h00;
      e.col = 16'(k % SW);
      e.row = 16'(k / SW);
      e.sof = (k == 0);
      e.eol = ((k % SW) == SW - 1);
      e.eof = (k == SN - 1);
      exp_q.push_back(e);
      if (cv) exp_vcnt++;
      if (k == SN - 1) exp_done_cyc = cyc + 3;
   endtask

   // Sobel-X response for raster slot k; valid once the 3x3 window is filled
   function automatic void l_model(input int k, output bit cv, output logic [7:0] pix);
      int r, c, gx, a0, a1, a2, b0, b1, b2;
      r = k / 256;
      c = k % 256;
      cv = 0;
      pix = 8'h00;
      if (r >= 2 && c >= 2) begin
         a0 = int'(img[(r-2)*256 + c]);
         a1 = int'(img[(r-1)*256 + c]);
         a2 = int'(img[r*256 + c]);
         b0 = int'(img[(r-2)*256 + c - 2]);
         b1 = int'(img[(r-1)*256 + c - 2]);
         b2 = int'(img[r*256 + c - 2]);
         gx = (a0 + 2*a1 + a2) - (b0 + 2*b1 + b2);
         if (gx < 0) gx = -gx;
         if (gx > 255) gx = 255;
         cv = 1;
         pix = 8'(gx);
      end
   endfunction

   // scoreboard for the 4x3 instance: exact emission cycle, idle zeros, done pulse
   task automatic mon_small();
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
               e = exp_q.pop_front();
               chk("s_valid", 64'(s_out_valid), 64'(1));
               chk("s_pix", 64'(s_out_pix), 64'(e.pix));
               chk("s_col", 64'(s_out_col), 64'(e.col));
               chk("s_row", 64'(s_out_row), 64'(e.row));
               chk("s_sof", 64'(s_out_sof), 64'(e.sof));
               chk("s_eol", 64'(s_out_eol), 64'(e.eol));
               chk("s_eof", 64'(s_out_eof), 64'(e.eof));
            end else begin
               chk("s_idle_valid", 64'(s_out_valid), 64'(0));
               chk("s_idle_pix", 64'(s_out_pix), 64'(0));
            end
            chk("s_done", 64'(s_done), 64'(cyc == exp_done_cyc));
         end
      end
   endtask

   // scoreboard for the 256x256 instance: emission order and contents
   task automatic mon_large();
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && l_out_valid) begin
            l_emit_cnt++;
            if (expl_q.size() == 0) begin
               chk("l_extra_emit", 64'(l_out_valid), 64'(0));
            end else begin
               e = expl_q.pop_front();
               chk("l_pix", 64'(l_out_pix), 64'(e.pix));
               chk("l_col", 64'(l_out_col), 64'(e.col));
               chk("l_row", 64'(l_out_row), 64'(e.row));
               chk("l_sof", 64'(l_out_sof), 64'(e.sof));
               chk("l_eol", 64'(l_out_eol), 64'(e.eol));
               chk("l_eof", 64'(l_out_eof), 64'(e.eof));
            end
         end
      end
   endtask

   task automatic do_start_s();
      @(posedge clk); #1;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      exp_vcnt = 0;
      exp_err = 0;
      chk("s_busy_after_start", 64'(s_busy), 64'(1));
      chk("s_err_cleared", 64'(s_err), 64'(0));
      chk("s_vcnt_cleared", 64'(s_valid_cnt), 64'(0));
   endtask

   // one 4x3 frame; conv result of each slot driven the following cycle
   task automatic run_frame(input bit toggle, input bit directed, input bit stray,
                            input bit restart, input int extra);
      int k = 0;
      int step = 0;
      bit pend = 0;
      bit pcv = 0;
      logic [7:0] ppix = 8'h00;
      bit issue, cv, stray_used;
      logic [7:0] pix;
      stray_used = 0;
      while (k < SN || pend) begin
         @(posedge clk); #1;
         issue = (k < SN) && (!toggle || (step % 2 == 0));
         s_start = restart && issue && (k == 5);
         if (pend) begin
            s_conv_valid = pcv;
            s_conv_pix = pcv ? ppix : 8'($urandom_range(0, 255));
         end else if (stray && !stray_used) begin
            s_conv_valid = 1'b1;
            s_conv_pix = 8'hEE;
            stray_used = 1;
            exp_err = 1;
         end else begin
            s_conv_valid = 1'b0;
            s_conv_pix = 8'($urandom_range(0, 255));
         end
         s_in_valid = issue;
         if (issue) begin
            if (directed) begin
               cv = (k == 5) || (k == 6);
               pix = (k == 5) ? 8'h11 : 8'h22;
            end else begin
               cv = 1'($urandom_range(0, 1));
               pix = 8'($urandom_range(0, 255));
            end
            push_s(k, cv, pix);
            pend = 1;
            pcv = cv;
            ppix = pix;
            k++;
         end else begin
            pend = 0;
         end
         step++;
      end
      for (int e = 0; e < extra; e++) begin
         @(posedge clk); #1;
         s_start = 1'b0;
         s_in_valid = 1'b1;
         s_conv_valid = 1'b0;
         exp_err = 1;
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      s_conv_valid = 1'b0;
      s_start = 1'b0;
   endtask

   task automatic finish_small(input string tag);
      repeat (6) @(posedge clk);
      #1;
      chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
      chk({tag, "_valid_cnt"}, 64'(s_valid_cnt), 64'(exp_vcnt));
      chk({tag, "_err"}, 64'(s_err), 64'(exp_err));
      chk({tag, "_busy_idle"}, 64'(s_busy), 64'(0));
      chk({tag, "_state_idle"}, 64'(s_fsm_state), 64'(0));
   endtask

   initial begin
      bit pend, pcv, cv, seen;
      logic [7:0] ppix, pix;
      int lcv_cnt;
      exp_t e;

      rst = 1'b1;
      s_start = 0; s_in_valid = 0; s_conv_valid = 0; s_conv_pix = 0;
      l_start = 0; l_in_valid = 0; l_conv_valid = 0; l_conv_pix = 0;
      fork
         mon_small();
         mon_large();
      join_none

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(s_out_valid), 64'(0));
      chk("rst_out_pix", 64'(s_out_pix), 64'(0));
      chk("rst_out_col", 64'(s_out_col), 64'(0));
      chk("rst_out_row", 64'(s_out_row), 64'(0));
      chk("rst_flags", 64'({s_out_sof, s_out_eol, s_out_eof}), 64'(0));
      chk("rst_busy_done", 64'({s_busy, s_done}), 64'(0));
      chk("rst_valid_cnt", 64'(s_valid_cnt), 64'(0));
      chk("rst_err", 64'(s_err), 64'(0));
      rst = 1'b0;
      mon_en = 1;

      // directed frame: contiguous slots, valid results on slots 5 and 6
      do_start_s();
      run_frame(0, 1, 0, 0, 0);
      finish_small("f_direct");
      chk("f_direct_vcnt2", 64'(s_valid_cnt), 64'(2));

      // same frame with gapped input and an ignored start mid-frame
      do_start_s();
      run_frame(1, 1, 0, 1, 0);
      finish_small("f_gapped");

      // in_valid while idle raises err; the next start clears it
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      chk("idle_in_valid_err", 64'(s_err), 64'(1));
      do_start_s();

      // random gapped frame with one unpaired conv_valid
      run_frame(1, 0, 1, 0, 0);
      finish_small("f_stray");

      // random contiguous frame followed by surplus slots that must be dropped
      do_start_s();
      run_frame(0, 0, 0, 0, 3);
      finish_small("f_extra");

      // reset after 7 emissions aborts the frame
      do_start_s();
      pend = 0; pcv = 0; ppix = 8'h00;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         s_conv_valid = pend && pcv;
         s_conv_pix = ppix;
         s_in_valid = 1'b1;
         rst = (k == 8);
         cv = 1'($urandom_range(0, 1));
         pix = 8'($urandom_range(0, 255));
         if (k < 7) push_s(k, cv, pix);
         pend = 1; pcv = cv; ppix = pix;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      s_in_valid = 1'b0;
      s_conv_valid = 1'b0;
      chk("abort_out_valid", 64'(s_out_valid), 64'(0));
      chk("abort_out_pix", 64'(s_out_pix), 64'(0));
      chk("abort_coords", 64'({s_out_col, s_out_row}), 64'(0));
      chk("abort_flags", 64'({s_out_sof, s_out_eol, s_out_eof}), 64'(0));
      chk("abort_busy_done", 64'({s_busy, s_done}), 64'(0));
      chk("abort_valid_cnt", 64'(s_valid_cnt), 64'(0));
      chk("abort_err", 64'(s_err), 64'(0));
      repeat (4) @(posedge clk);
      #1;
      chk("abort_queue_empty", 64'(exp_q.size()), 64'(0));
      do_start_s();
      run_frame(0, 0, 0, 0, 0);
      finish_small("f_reframe");

      // full-size frame with a Sobel-X result stream
      for (int i = 0; i < LN; i++) img[i] = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      l_start = 1'b1;
      @(posedge clk); #1;
      l_start = 1'b0;
      lcv_cnt = 0;
      pend = 0; pcv = 0; ppix = 8'h00;
      for (int k = 0; k <= LN; k++) begin
         @(posedge clk); #1;
         l_conv_valid = pend && pcv;
         l_conv_pix = pend ? ppix : 8'h00;
         l_in_valid = (k < LN);
         pend = (k < LN);
         if (k < LN) begin
            l_model(k, cv, pix);
            e.cyc = 32'(cyc + 2);
            e.pix = pix;
            e.col = 16'(k % 256);
            e.row = 16'(k / 256);
            e.sof = (k == 0);
            e.eol = ((k % 256) == 255);
            e.eof = (k == LN - 1);
            expl_q.push_back(e);
            if (cv) lcv_cnt++;
            pcv = cv;
            ppix = pix;
         end
      end
      @(posedge clk); #1;
      l_in_valid = 1'b0;
      l_conv_valid = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (l_done) seen = 1;
      end
      chk("l_done_seen", 64'(seen), 64'(1));
      chk("l_emit_count", 64'(l_emit_cnt), 64'(LN));
      chk("l_queue_empty", 64'(expl_q.size()), 64'(0));
      chk("l_valid_cnt", 64'(l_valid_cnt), 64'(lcv_cnt));
      chk("l_err", 64'(l_err), 64'(0));
      chk("l_busy_idle", 64'(l_busy), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/conv_out_framer.md
CONV_OUT_FRAMER -- requirements
Module: conv_out_framer

Interface
REQ-001 Parameter WIDTH, default 256, pixels per row.
REQ-002 Parameter HEIGHT, default 256, rows per frame.
REQ-003 Parameter BITW, default 8, pixel width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to arm framing of a new frame.
REQ-007 in_valid  in  1  upstream pixel strobe, the same signal driving the convolution core's input.
REQ-008 conv_valid  in  1  convolution core output valid.
REQ-009 conv_pix  in  BITW  convolution core output pixel.
REQ-010 out_valid  out  1  one framed pixel this cycle.
REQ-011 out_pix  out  BITW  framed pixel value.
REQ-012 out_col / out_row  out  16 each  raster coordinates of out_pix.
REQ-013 out_sof / out_eol / out_eof  out  1 each  first pixel of frame / last of row / last of frame, qualified by out_valid.
REQ-014 busy  out  1  high while in RUN.
REQ-015 done  out  1  one-cycle pulse after the last pixel of a frame is emitted.
REQ-016 valid_cnt  out  32  number of slots in the current or last frame that carried conv_valid=1.
REQ-017 err  out  1  sticky protocol error flag.

Function
REQ-018 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when the pixel at (HEIGHT-1, WIDTH-1) is emitted; DONE->IDLE unconditionally after one cycle.
REQ-019 On IDLE->RUN: column and row counters, valid_cnt, and err cleared to 0.
REQ-020 start in RUN or DONE: ignored, no counter change.
REQ-021 Slot pairing: in_valid high in cycle t defines a slot; conv_valid/conv_pix in cycle t+1 belong to that slot.
REQ-022 Each slot in RUN produces exactly one output, out_valid=1 in cycle t+2.
REQ-023 out_pix = conv_pix when the slot's conv_valid=1, else 0 (borders and warm-up zero-filled).
REQ-024 No emission when no slot is pending: out_valid=0 and out_pix held at 0.
REQ-025 out_col increments per emission and wraps from WIDTH-1 to 0, incrementing out_row.
REQ-026 out_sof=1 only at (0,0); out_eol=1 at col WIDTH-1; out_eof=1 at (HEIGHT-1, WIDTH-1).
REQ-027 valid_cnt increments by 1 per slot with conv_valid=1; saturates at 2^32-1.
REQ-028 done=1 in the cycle the FSM is in DONE; busy=1 exactly in RUN.
REQ-029 Gaps in in_valid are legal; pairing holds per slot, output stalls correspondingly.
REQ-030 Sets err: conv_valid=1 in a cycle that is not t+1 of a RUN slot.
REQ-031 Sets err: in_valid=1 while in IDLE or DONE; no output produced.
REQ-032 Sets err: in_valid=1 after the frame's last slot has been issued.
REQ-033 Slots issued in RUN beyond WIDTH*HEIGHT are dropped, never emitted.
REQ-034 A slot issued on the last RUN cycle still completes its emission.

Reset
REQ-035 rst=1 forces IDLE; out_valid, out_pix, out_col, out_row, out_sof, out_eol, out_eof, busy, done, valid_cnt, err, and the slot pipeline all 0 on the next edge.
REQ-036 rst mid-frame aborts: no further emissions, no done pulse, pending slots discarded.
REQ-037 rst has priority over start in the same cycle.

Verification
REQ-038 WIDTH=4, HEIGHT=3: start, then 12 contiguous in_valid cycles with conv_valid=1 only on slots 5,6 and pix 0x11,0x22 -> 12 outputs; out_pix 0 except index 5=0x11, 6=0x22; sof at index 0, eol at 3,7,11, eof at 11; done one cycle after index 11; valid_cnt=2; err=0.
REQ-039 Same frame with in_valid toggling 1,0,1,0 -> the same 12 values/coordinates, out_valid pattern spaced matching input, 2-cycle latency per slot.
REQ-040 in_valid pulse with FSM in IDLE -> no out_valid, err=1; next start clears err to 0.
REQ-041 conv_valid=1 with no preceding slot during RUN -> err=1, output stream unchanged.
REQ-042 rst asserted after 7 emissions -> all outputs 0 next cycle, no done; new start re-frames from (0,0) with sof.
REQ-043 Default 256x256 with Sobel-X Top_conv and 65536-pixel raster -> exactly 65536 outputs, eof at (255,255), valid_cnt equals conv_valid count from the bench model.
